rk4_result_framer: RTL
======================

// Module: rk4_result_framer
// PURPOSE
//  Downstream stage of the RK4 projectile core. Buffers (ti, yi) Q16.16 sample pairs
//  from the core and serializes each pair as 8 little-endian bytes (ti b0..b3, then yi b0..b3)
//  into the byte-wide UART transmitter. On end-of-run it appends the 4-byte marker 0xDEADBEEF.
//  It decouples the core's compute rate from UART line rate.
// PARAMETERS
//  DATA_W      32            width of ti / yi words (Q16.16)
//  FIFO_DEPTH  4             pair entries buffered; power of 2, >= 2
//  EOS_WORD    32'hDEADBEEF  end-of-stream marker, sent LSB byte first
// PORTS
//  clk         in   1        system clock
//  rst         in   1        synchronous reset, active-high
//  pair_valid  in   1        core presents a (ti, yi) pair
//  pair_ready  out  1        framer accepts the pair this cycle when pair_valid && pair_ready
//  pair_t      in   DATA_W   ti, Q16.16
//  pair_y      in   DATA_W   yi, Q16.16
//  run_done    in   1        one-cycle pulse: core finished, no more pairs this run
//  tx_data     out  8        byte to UART TX
//  tx_start    out  1        one-cycle request to send tx_data
//  tx_busy     in   1        UART TX is shifting a frame
//  eos_sent    out  1        one-cycle pulse after last EOS byte's tx_busy falls
//  framer_idle out  1        FIFO empty, no EOS pending, FSM in IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO cleared, FSM->IDLE, eos_pending=0; outputs: pair_ready=1,
//   tx_start=0, tx_data=8'h00, eos_sent=0, framer_idle=1. Reset mid-frame abandons the frame.
//  Input: pair_ready = !full && !eos_pending. Accepted pair is written at that posedge.
//   pair_valid with pair_ready=0 is not accepted; the core holds the pair stable.
//  run_done sets eos_pending. run_done with an accepted pair in the same cycle: that pair is
//   buffered, and EOS follows it. run_done while eos_pending=1 is ignored (no second marker).
//  FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO.
//   IDLE:    FIFO non-empty -> LOAD (source=pair); else eos_pending -> LOAD (source=EOS).
//            Pairs always drain before EOS.
//   LOAD:    latch a 64-bit shift word ({yi,ti}) or EOS_WORD; byte_cnt = 8 or 4; pop FIFO
//            if pair -> START.
//   START:   when tx_busy=0, tx_data = word[7:0] and tx_start=1 for exactly one cycle -> WAIT_HI.
//   WAIT_HI: wait for tx_busy=1 -> WAIT_LO.
//   WAIT_LO: wait for tx_busy=0; shift word right 8, byte_cnt-1. If byte_cnt!=0 -> START.
//            Otherwise -> IDLE; if source=EOS, clear eos_pending and pulse eos_sent.
//  tx_data holds its value from tx_start until the next tx_start.
//  Latency: a pair into an empty idle framer gives tx_start 2 cycles after acceptance.
//  FIFO: simultaneous push and pop is allowed when full. Pointers wrap modulo FIFO_DEPTH.
//   Full/empty use an extra pointer bit. No overflow is possible (gated by pair_ready).
//  Words are opaque bits; no arithmetic on data. byte_cnt is 4 bits wide.
//  framer_idle = (state==IDLE) && empty && !eos_pending.
// STRUCTURE
//  rk4_pkg: Q_W=32, Q_FRAC=16, EOS_WORD constant, PAIR_BYTES=8, EOS_BYTES=4,
//   typedef struct packed {logic [31:0] y, t;} rk4_pair_t, FSM state enum.
//  Sub-module rk4_pair_fifo: sync FIFO of rk4_pair_t, depth FIFO_DEPTH.
//   Ports: push/pop/full/empty.
//  The FSM and byte shifter stay in rk4_result_framer.
// TESTING
//  1 Single pair t=0x0001_999A, y=0x0004_D70A, then run_done; behavioural UART model
//    (busy 1 cycle after start, 10 cycles long) -> bytes 9A 99 01 00 0A D7 04 00 EF BE AD DE,
//    then one eos_sent pulse.
//  2 Burst of 6 pairs back-to-back with FIFO_DEPTH=4 -> pair_ready drops after 4
//    (plus 1 popped). All 48 bytes arrive in order with no loss or duplication.
//  3 run_done in the same cycle as an accepted 3rd pair -> 24 pair bytes, then EOS.
//    A second run_done while pending gives no extra marker.
//  4 tx_busy held high for 50 cycles before the first start -> tx_start waits.
//    Each tx_start is exactly 1 cycle and appears only when tx_busy=0.
//  5 Assert rst during the 5th byte of a pair -> all outputs hit reset values on the next
//    edge, FIFO empty, framer_idle=1. A new pair afterward is sent from b0.
//  6 Empty run (run_done only) -> exactly EF BE AD DE, eos_sent, framer_idle=1.

Source files
------------

// File: rtl/rk4_pkg.sv
// rk4_pkg: shared constants, pair type and framer FSM states for the RK4 result path
package rk4_pkg;
  localparam int Q_W = 32;
  localparam int Q_FRAC = 16;
  localparam int PAIR_BYTES = 8;
  localparam int EOS_BYTES = 4;
  localparam logic [Q_W-1:0] EOS_WORD = 32'hDEADBEEF;
  typedef struct packed {
    logic [Q_W-1:0] y;
    logic [Q_W-1:0] t;
  } rk4_pair_t;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;
endpackage

// File: rtl/rk4_pair_fifo.sv
// rk4_pair_fifo: synchronous FIFO of (t, y) pairs, full/empty from an extra pointer bit
module rk4_pair_fifo
  import rk4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  rk4_pair_t din,
  output rk4_pair_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  rk4_pair_t mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/rk4_result_framer.sv
// rk4_result_framer: buffers (t, y) pairs and serializes them LSB-first to a UART, then an EOS marker
module rk4_result_framer #(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] EOS_WORD = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pair_valid,
  output logic              pair_ready,
  input  logic [DATA_W-1:0] pair_t,
  input  logic [DATA_W-1:0] pair_y,
  input  logic              run_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              eos_sent,
  output logic              framer_idle
);
  import rk4_pkg::*;
  state_t state, nxt;
  rk4_pair_t dout;
  logic full, empty, src_eos, eos_pending;
  logic [2*DATA_W-1:0] word;
  logic [3:0] byte_cnt;
  logic [7:0] tx_q;
  assign pair_ready = !full && !eos_pending;
  assign tx_start = (state == START) && !tx_busy;
  assign tx_data = tx_start ? word[7:0] : tx_q;
  assign eos_sent = (state == WAIT_LO) && !tx_busy && (byte_cnt == 4'd1) && src_eos;
  assign framer_idle = (state == IDLE) && empty && !eos_pending;
  rk4_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pair_valid && pair_ready),
    .pop  ((state == LOAD) && !src_eos),
    .din  ('{y: pair_y, t: pair_t}),
    .dout (dout),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (!empty || eos_pending) ? LOAD : IDLE;
      LOAD:    nxt = START;
      START:   nxt = tx_busy ? START : WAIT_HI;
      WAIT_HI: nxt = tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: nxt = tx_busy ? WAIT_LO : (byte_cnt == 4'd1) ? IDLE : START;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word <= '0;
      byte_cnt <= '0;
      src_eos <= 1'b0;
      eos_pending <= 1'b0;
      tx_q <= '0;
    end else begin
      state <= nxt;
      // pairs drain first: EOS is only chosen when the FIFO is empty
      if (state == IDLE) src_eos <= empty;
      if (state == LOAD) begin
        word <= src_eos ? {{DATA_W{1'b0}}, EOS_WORD} : dout;
        byte_cnt <= src_eos ? 4'(EOS_BYTES) : 4'(PAIR_BYTES);
      end
      if (tx_start) tx_q <= word[7:0];
      if ((state == WAIT_LO) && !tx_busy) begin
        word <= word >> 8;
        byte_cnt <= byte_cnt - 4'd1;
      end
      eos_pending <= eos_sent ? 1'b0 : (eos_pending || run_done);
    end
  end
endmodule
